// File: rtl/axi_lite_master_arb.sv
// axi_lite_master_arb: round-robin arbiter for two requesters sharing one AXI-lite master port
module axi_lite_master_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*DATA_W/8-1:0]   req_wstrb,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic                    grant_id,
  output logic [ADDR_W-1:0]       AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_W-1:0]       WDATA,
  output logic [DATA_W/8-1:0]     WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);
  localparam int SW = DATA_W / 8;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d, rsp_valid_q, rsp_valid_d;
  logic grant_q, grant_d, prio_q, prio_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic pick, wr;
  // prio_q names the requester that wins when both ask at once
  assign pick = (req_valid[0] && req_valid[1]) ? prio_q : req_valid[1];
  assign wr = req_write[pick];
  assign req_ready = (state_q == IDLE && |req_valid) ? (pick ? 2'b10 : 2'b01) : 2'b00;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    grant_d = grant_q;
    prio_d = prio_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d = bready_q;
    rready_d = rready_q;
    rsp_valid_d = 2'b00;
    case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = pick;
        prio_d = ~pick;
        addr_d = pick ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        wdata_d = pick ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
        wstrb_d = pick ? req_wstrb[SW +: SW] : req_wstrb[0 +: SW];
        rdata_d = '0;
        resp_d = 2'b00;
        awvalid_d = wr;
        wvalid_d = wr;
        arvalid_d = ~wr;
        state_d = wr ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        if (AWREADY) awvalid_d = 1'b0;
        if (WREADY) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d = WR_RESP;
        end
      end
      WR_RESP: if (BVALID) begin
        resp_d = BRESP;
        bready_d = 1'b0;
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end
      RD_REQ: if (ARREADY) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: if (RVALID) begin
        rdata_d = RDATA;
        resp_d = RRESP;
        rready_d = 1'b0;
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q <= 2'b00;
      grant_q <= 1'b0;
      prio_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q <= 1'b0;
      rready_q <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      grant_q <= grant_d;
      prio_q <= prio_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q <= bready_d;
      rready_q <= rready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign WDATA = wdata_q;
  assign WSTRB = wstrb_q;
  assign AWVALID = awvalid_q;
  assign WVALID = wvalid_q;
  assign ARVALID = arvalid_q;
  assign BREADY = bready_q;
  assign RREADY = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_axi_lite_master_arb.sv
// tb_axi_lite_master_arb: scoreboard bench with a delay-configurable AXI-lite slave model
module tb_axi_lite_master_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef struct packed {logic [1:0] v; logic [31:0] d; logic [1:0] r;} rsp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [1:0] req_valid = 0, req_ready, req_write = 0, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr = 0;
  logic [2*DW-1:0] req_wdata = 0;
  logic [2*DW/8-1:0] req_wstrb = 0;
  logic [DW-1:0] rsp_rdata;
  logic busy, grant_id;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA, RDATA = 0;
  logic [DW/8-1:0] WSTRB;
  logic [1:0] BRESP = 0, RRESP = 0;
  logic AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic AWREADY = 0, WREADY = 0, ARREADY = 0, BVALID = 0, RVALID = 0;
  axi_lite_master_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .grant_id(grant_id),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );
  int vectors = 0, miscompares = 0, cyc = 0;
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] b_resp, r_resp;
  logic [31:0] r_data;
  int aw_hs, w_hs, b_hs, ar_hs, r_hs, proto_err, rdy_err;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit aw_got, w_got, ar_got, b_pend, r_pend, b_fire, r_fire, aw_wait, w_wait, ar_wait;
  logic [AW-1:0] aw_prev, ar_prev;
  logic [DW+DW/8-1:0] w_prev;
  logic [AW-1:0] aw_log[$], ar_log[$], exp_aw_q[$], exp_ar_q[$];
  logic [DW+DW/8-1:0] w_log[$], exp_w_q[$];
  rsp_t got_q[$], exp_q[$];
  int got_t[$], gnt_log[$], gnt_t[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && rsp_valid != 2'b00) begin
      got_q.push_back({rsp_valid, rsp_rdata, rsp_resp});
      got_t.push_back(cyc);
    end
  end
  // slave decides at each negedge; a handshake seen here completes at the following posedge
  always @(negedge clk) begin
    if (rst) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      BRESP = 0; RRESP = 0; RDATA = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
      b_fire = 0; r_fire = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (aw_wait && (!AWVALID || AWADDR !== aw_prev)) proto_err++;
      if (w_wait && (!WVALID || {WDATA, WSTRB} !== w_prev)) proto_err++;
      if (ar_wait && (!ARVALID || ARADDR !== ar_prev)) proto_err++;
      if (b_fire) begin BVALID = 0; b_fire = 0; b_pend = 0; end
      if (r_fire) begin RVALID = 0; RDATA = 0; r_fire = 0; r_pend = 0; end
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
      if (ar_got) begin r_pend = 1; r_cnt = 0; ar_got = 0; end
      if (b_pend && !BREADY) rdy_err++;
      if (r_pend && !RREADY) rdy_err++;
      if (b_pend && !BVALID) begin
        if (b_cnt >= b_dly) begin BVALID = 1; BRESP = b_resp; end else b_cnt++;
      end
      if (BVALID && BREADY) begin b_fire = 1; b_hs++; end
      if (r_pend && !RVALID) begin
        if (r_cnt >= r_dly) begin RVALID = 1; RDATA = r_data; RRESP = r_resp; end else r_cnt++;
      end
      if (RVALID && RREADY) begin r_fire = 1; r_hs++; end
      AWREADY = AWVALID && aw_cnt >= aw_dly;
      if (AWVALID && !AWREADY) aw_cnt++;
      if (AWVALID && AWREADY) begin aw_got = 1; aw_hs++; aw_cnt = 0; aw_log.push_back(AWADDR); end
      WREADY = WVALID && w_cnt >= w_dly;
      if (WVALID && !WREADY) w_cnt++;
      if (WVALID && WREADY) begin w_got = 1; w_hs++; w_cnt = 0; w_log.push_back({WDATA, WSTRB}); end
      ARREADY = ARVALID && ar_cnt >= ar_dly;
      if (ARVALID && !ARREADY) ar_cnt++;
      if (ARVALID && ARREADY) begin ar_got = 1; ar_hs++; ar_cnt = 0; ar_log.push_back(ARADDR); end
      aw_wait = AWVALID && !AWREADY; aw_prev = AWADDR;
      w_wait = WVALID && !WREADY; w_prev = {WDATA, WSTRB};
      ar_wait = ARVALID && !ARREADY; ar_prev = ARADDR;
    end
  end
  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete(); got_q.delete(); got_t.delete();
    exp_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    gnt_log.delete(); gnt_t.delete();
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; proto_err = 0; rdy_err = 0;
  endtask
  task automatic slave_cfg(input int a, input int w, input int b, input int ar, input int r,
                           input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    b_resp = br; r_resp = rr; r_data = rd;
  endtask
  task automatic apply_reset();
    rst = 1; req_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    clear_logs();
  endtask
  // presents n0/n1 requests, logging expectations at each accept; valid held until all accepted
  task automatic drive(input int n0, input int n1, input logic [1:0] wr, input int max_cyc, output bit to);
    int n[2];
    bit drop[2];
    int k;
    rsp_t e;
    n[0] = n0; n[1] = n1; drop[0] = 0; drop[1] = 0; k = 0;
    req_write = wr;
    req_valid = {n1 > 0, n0 > 0};
    while (req_valid != 2'b00 && k < max_cyc) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        if (drop[i]) begin
          req_valid[i] = 1'b0;
          drop[i] = 0;
        end else if (req_valid[i] && req_ready[i]) begin
          e.v = (i == 0) ? 2'b01 : 2'b10;
          e.d = wr[i] ? 32'h0 : r_data;
          e.r = wr[i] ? b_resp : r_resp;
          exp_q.push_back(e);
          if (wr[i]) begin
            exp_aw_q.push_back(req_addr[i*AW +: AW]);
            exp_w_q.push_back({req_wdata[i*DW +: DW], req_wstrb[i*4 +: 4]});
          end else exp_ar_q.push_back(req_addr[i*AW +: AW]);
          gnt_log.push_back(i);
          gnt_t.push_back(cyc);
          n[i]--;
          if (n[i] == 0) drop[i] = 1;
        end
      end
      @(negedge clk);
      k++;
    end
    to = req_valid != 2'b00;
    req_valid = 0;
  endtask
  task automatic settle(input int max_cyc, output bit to);
    int k = 0;
    while ((got_q.size() < exp_q.size() || busy) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    to = k >= max_cyc;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if ({busy, grant_id, req_ready} !== 4'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {busy, grant_id, req_ready});
    end
    vectors++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 5'b0) begin
      miscompares++; $display("FAIL reset_chan: got %b want 00000", {AWVALID, WVALID, ARVALID, BREADY, RREADY});
    end
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_resp} !== 36'h0) begin
      miscompares++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_rdata, rsp_resp});
    end
  endtask
  task automatic test_single_read();
    bit to;
    rsp_t g, e;
    clear_logs();
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEAD_BEEF);
    req_addr = {32'h0, 32'h10};
    drive(1, 0, 2'b00, 20, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL rd_grant: got timeout want accept"); end
    settle(40, to);
    vectors++;
    if (got_q.size() != 1 || gnt_t.size() != 1) begin
      miscompares++; $display("FAIL rd_count: got %0d want 1", got_q.size());
    end else begin
      vectors++;
      if (got_t[0] - gnt_t[0] != 3) begin
        miscompares++; $display("FAIL rd_latency: got %0d want 3", got_t[0] - gnt_t[0]);
      end
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e || g !== {2'b01, 32'hDEAD_BEEF, 2'b00}) begin
        miscompares++; $display("FAIL rd_rsp: got %h want %h", g, e);
      end
    end
    vectors++;
    if (ar_log.size() != 1 || ar_log[0] !== 32'h10) begin
      miscompares++; $display("FAIL rd_araddr: got %0d entries want one 0x10", ar_log.size());
    end
  endtask
  task automatic test_alternate();
    bit to;
    rsp_t g, e;
    apply_reset();
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    req_addr = {32'h200, 32'h100};
    req_wdata = {32'h2222_0002, 32'h1111_0001};
    req_wstrb = {4'h3, 4'hF};
    drive(3, 3, 2'b11, 100, to);
    settle(60, to);
    vectors++;
    if (to || gnt_log.size() != 6 || got_q.size() != 6) begin
      miscompares++; $display("FAIL alt_count: got %0d grants %0d rsps want 6 6", gnt_log.size(), got_q.size());
    end
    for (int k = 0; k < gnt_log.size(); k++) begin
      vectors++;
      if (gnt_log[k] != k % 2) begin
        miscompares++; $display("FAIL alt_grant%0d: got %0d want %0d", k, gnt_log[k], k % 2);
      end
      if (k > 0) begin
        vectors++;
        if (gnt_t[k] - gnt_t[k-1] != 4) begin
          miscompares++; $display("FAIL alt_gap%0d: got %0d want 4", k, gnt_t[k] - gnt_t[k-1]);
        end
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL alt_rsp: got %h want %h", g, e); end
    end
    vectors++;
    if (aw_log !== exp_aw_q || w_log !== exp_w_q) begin
      miscompares++; $display("FAIL alt_awdata: got %0d/%0d beats want %0d", aw_log.size(), w_log.size(), exp_aw_q.size());
    end
  endtask
  task automatic test_split_write(input int a, input int w);
    bit to;
    rsp_t g, e;
    clear_logs();
    slave_cfg(a, w, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    req_addr = {32'hA0 + a, 32'h0};
    req_wdata = {32'h5A5A_0000 + w, 32'h0};
    req_wstrb = {4'h6, 4'h0};
    drive(0, 1, 2'b10, 20, to);
    settle(40, to);
    vectors++;
    if ({aw_hs, w_hs, b_hs} !== {32'd1, 32'd1, 32'd1}) begin
      miscompares++; $display("FAIL split%0d%0d_hs: got aw%0d w%0d b%0d want 1 1 1", a, w, aw_hs, w_hs, b_hs);
    end
    vectors++;
    if (proto_err != 0 || rdy_err != 0) begin
      miscompares++; $display("FAIL split%0d%0d_proto: got %0d/%0d want 0", a, w, proto_err, rdy_err);
    end
    vectors++;
    if (got_q.size() != 1 || aw_log !== exp_aw_q || w_log !== exp_w_q) begin
      miscompares++; $display("FAIL split%0d%0d_beats: got %0d rsps want 1", a, w, got_q.size());
    end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e || g.v !== 2'b10) begin miscompares++; $display("FAIL split%0d%0d_rsp: got %h want %h", a, w, g, e); end
    end
  endtask
  task automatic test_error_resp();
    bit to;
    rsp_t g, e;
    int lat[2];
    clear_logs();
    slave_cfg(0, 0, 5, 0, 2, 2'b10, 2'b11, 32'h1234_5678);
    req_addr = {32'h0, 32'h40};
    req_wdata = {32'h0, 32'h7777_7777};
    req_wstrb = {4'h0, 4'hF};
    drive(1, 0, 2'b01, 20, to);
    settle(40, to);
    drive(1, 0, 2'b00, 20, to);
    settle(40, to);
    lat[0] = 8; lat[1] = 5;
    vectors++;
    if (got_q.size() != 2 || gnt_t.size() != 2) begin
      miscompares++; $display("FAIL err_count: got %0d want 2", got_q.size());
    end
    for (int k = 0; k < 2 && k < got_t.size() && k < gnt_t.size(); k++) begin
      vectors++;
      if (got_t[k] - gnt_t[k] != lat[k]) begin
        miscompares++; $display("FAIL err_latency%0d: got %0d want %0d", k, got_t[k] - gnt_t[k], lat[k]);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL err_rsp: got %h want %h", g, e); end
    end
    vectors++;
    if (rdy_err != 0) begin miscompares++; $display("FAIL err_ready_held: got %0d drops want 0", rdy_err); end
  endtask
  task automatic test_reset_mid();
    bit to;
    int k;
    rsp_t g, e;
    clear_logs();
    slave_cfg(0, 0, 0, 0, 30, 2'b00, 2'b00, 32'hBAD0_BAD0);
    req_addr = {32'h24, 32'h20};
    drive(1, 0, 2'b00, 20, to);
    k = 0;
    while (!RREADY && k < 20) begin @(negedge clk); k++; end
    vectors++;
    if (k >= 20) begin miscompares++; $display("FAIL mid_reach: got timeout want RREADY"); end
    rst = 1;
    @(negedge clk);
    #1;
    vectors++;
    if ({busy, RREADY, rsp_valid, ARVALID} !== 5'b0) begin
      miscompares++; $display("FAIL mid_abort: got %b want 00000", {busy, RREADY, rsp_valid, ARVALID});
    end
    rst = 0;
    clear_logs();
    repeat (5) @(negedge clk);
    vectors++;
    if (got_q.size() != 0) begin miscompares++; $display("FAIL mid_silent: got %0d rsps want 0", got_q.size()); end
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b01, 32'hCAFE_0001);
    drive(1, 1, 2'b00, 40, to);
    settle(40, to);
    vectors++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 1) begin
      miscompares++; $display("FAIL mid_prio: got %0d grants first %0d want 0 then 1", gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : -1);
    end
    vectors++;
    if (got_q.size() != 2) begin miscompares++; $display("FAIL mid_count: got %0d want 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL mid_rsp: got %h want %h", g, e); end
    end
    vectors++;
    if (ar_log !== exp_ar_q) begin miscompares++; $display("FAIL mid_araddr: got %0d beats want %0d", ar_log.size(), exp_ar_q.size()); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    clear_logs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_alternate();
    test_split_write(0, 3);
    test_split_write(3, 0);
    test_error_resp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
